// File: rtl/imem_req_scheduler_if.sv
// Instruction-side request/fill bus between the I-cache, prefetcher, memory arbiter and the scheduler.
interface imem_req_scheduler_if #(parameter int ADDR_W = 64);
  logic              ic_miss_valid;
  logic [ADDR_W-1:0] ic_miss_addr;
  logic              ic_miss_done;
  logic              pf_request_valid;
  logic [ADDR_W-1:0] pf_requested_addr;
  logic              pf_stall;
  logic              pf_flush;
  logic              mem_port_avail;
  logic [1:0]        proc2mem_command;
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [3:0]        mem2proc_response;
  logic [3:0]        mem2proc_tag;
  logic [63:0]       mem2proc_data;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [63:0]       fill_data;
  logic              fill_is_prefetch;

  modport master (
    input  ic_miss_valid, ic_miss_addr, pf_request_valid, pf_requested_addr, pf_flush,
           mem_port_avail, mem2proc_response, mem2proc_tag, mem2proc_data,
    output ic_miss_done, pf_stall, proc2mem_command, proc2mem_addr,
           fill_valid, fill_addr, fill_data, fill_is_prefetch
  );

  modport slave (
    output ic_miss_valid, ic_miss_addr, pf_request_valid, pf_requested_addr, pf_flush,
           mem_port_avail, mem2proc_response, mem2proc_tag, mem2proc_data,
    input  ic_miss_done, pf_stall, proc2mem_command, proc2mem_addr,
           fill_valid, fill_addr, fill_data, fill_is_prefetch
  );
endinterface

// File: rtl/imem_req_scheduler.sv
// Arbitrates the I-side memory port between demand misses and a deduplicating prefetch FIFO,
// tracks in-flight requests per memory tag and routes returning data back as tagged fills.
module imem_req_scheduler #(
  parameter int ADDR_W          = 64,
  parameter int NUM_TAGS        = 15,
  parameter int MAX_OUTSTANDING = 8,
  parameter int PF_QDEPTH       = 4
) (
  input logic                 clk,
  input logic                 reset,
  imem_req_scheduler_if.master bus
);
  localparam int TAG_W = 4;
  localparam int TAGS  = 1 << TAG_W;
  localparam int CNT_W = $clog2(NUM_TAGS + 1);
  localparam int PTR_W = $clog2(PF_QDEPTH);
  localparam logic [TAGS-1:0]  TAG_MASK  = TAGS'((1 << (NUM_TAGS + 1)) - 2);
  localparam logic [CNT_W-1:0] MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(PF_QDEPTH);
  localparam logic [1:0]       BUS_NONE  = 2'd0;
  localparam logic [1:0]       BUS_LOAD  = 2'd1;

  logic [TAGS-1:0]   tbl_valid, tbl_demand;
  logic [ADDR_W-1:0] tbl_addr [TAGS];
  logic [CNT_W-1:0]  outstanding;

  logic [ADDR_W-1:0]    pf_mem [PF_QDEPTH];
  logic [PF_QDEPTH-1:0] pf_vld;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [PTR_W:0]       pf_count;

  logic              demand_hit, head_hit, pf_dup;
  logic [TAG_W-1:0]  demand_idx;
  logic              pf_empty, pf_full, can_issue, issue_demand, issue_pf, resp_ok, accept;
  logic              head_pop, push, fill_hit, alloc_new, fill_free;
  logic [TAG_W-1:0]  resp, tag;
  logic [ADDR_W-1:0] issue_addr;

  assign resp = bus.mem2proc_response;
  assign tag  = bus.mem2proc_tag;

  // Hit checks all look at the table as it stands at the start of the cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    demand_hit = 1'b0;
    demand_idx = '0;
    head_hit   = 1'b0;
    pf_dup     = 1'b0;
    for (int i = 0; i < TAGS; i++) begin
      if (bus.ic_miss_valid && !demand_hit && tbl_valid[TAG_W'(i)] &&
          tbl_addr[TAG_W'(i)] == bus.ic_miss_addr) begin
        demand_hit = 1'b1;
        demand_idx = TAG_W'(i);
      end
      if (tbl_valid[TAG_W'(i)] && tbl_addr[TAG_W'(i)] == pf_mem[rd_ptr]) head_hit = 1'b1;
      if (tbl_valid[TAG_W'(i)] && tbl_addr[TAG_W'(i)] == bus.pf_requested_addr) pf_dup = 1'b1;
    end
    for (int j = 0; j < PF_QDEPTH; j++) begin
      if (pf_vld[PTR_W'(j)] && pf_mem[PTR_W'(j)] == bus.pf_requested_addr) pf_dup = 1'b1;
    end
  end

  assign pf_empty     = (pf_count == '0);
  assign pf_full      = (pf_count == FIFO_FULL);
  assign can_issue    = bus.mem_port_avail && (outstanding < MAX_OUT);
  assign issue_demand = can_issue && bus.ic_miss_valid && !demand_hit;
  assign issue_pf     = can_issue && !issue_demand && !pf_empty && !head_hit;
  assign issue_addr   = issue_demand ? bus.ic_miss_addr : (issue_pf ? pf_mem[rd_ptr] : '0);
  assign resp_ok      = TAG_MASK[resp];
  assign accept       = (issue_demand || issue_pf) && resp_ok;
  // A head already in flight is discarded without using the port.
  assign head_pop     = (can_issue && !pf_empty && head_hit) || (issue_pf && resp_ok);
  assign push         = bus.pf_request_valid && !pf_dup && (!pf_full || head_pop);
  assign fill_hit     = tbl_valid[tag];
  assign alloc_new    = accept && !tbl_valid[resp];
  assign fill_free    = fill_hit && !(accept && resp == tag);

  assign bus.ic_miss_done     = demand_hit || (issue_demand && resp_ok);
  assign bus.pf_stall         = pf_full;
  assign bus.proc2mem_command = (issue_demand || issue_pf) ? BUS_LOAD : BUS_NONE;
  assign bus.proc2mem_addr    = issue_addr;
  assign bus.fill_valid       = fill_hit;
  assign bus.fill_addr        = fill_hit ? tbl_addr[tag] : '0;
  assign bus.fill_data        = fill_hit ? bus.mem2proc_data : '0;
  assign bus.fill_is_prefetch = fill_hit && !tbl_demand[tag] && !(demand_hit && demand_idx == tag);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; later writes in this block win.
    if (reset) begin
      tbl_valid   <= '0;
      tbl_demand  <= '0;
      outstanding <= '0;
      pf_vld      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pf_count    <= '0;
    end else begin
      if (fill_hit)   tbl_valid[tag] <= 1'b0;
      if (demand_hit) tbl_demand[demand_idx] <= 1'b1;
      if (accept) begin
        tbl_valid[resp]  <= 1'b1;
        tbl_demand[resp] <= issue_demand;
      end
      outstanding <= outstanding + CNT_W'(alloc_new) - CNT_W'(fill_free);

      if (bus.pf_flush) begin
        pf_vld   <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        pf_count <= '0;
      end else begin
        if (head_pop) begin
          pf_vld[rd_ptr] <= 1'b0;
          rd_ptr         <= rd_ptr + 1'b1;
        end
        if (push) begin
          pf_vld[wr_ptr] <= 1'b1;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        pf_count <= pf_count + (PTR_W + 1)'(push) - (PTR_W + 1)'(head_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: address storage is not reset; the valid bits gate every use of it.
    if (accept) tbl_addr[resp] <= issue_addr;
    if (push && !bus.pf_flush) pf_mem[wr_ptr] <= bus.pf_requested_addr;
  end
endmodule

// File: tb/tb_imem_req_scheduler.sv
// Directed scenarios plus a randomized run, all checked against a queue/associative-array model.
module tb_imem_req_scheduler;
  localparam int DEPTH = 4;
  localparam int MAXO  = 8;

  typedef struct packed {
    logic        miss_valid;
    logic [63:0] miss_addr;
    logic        pf_valid;
    logic [63:0] pf_addr;
    logic        flush;
    logic        avail;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] data;
  } in_t;

  typedef struct packed {
    logic        done;
    logic        stall;
    logic [1:0]  cmd;
    logic [63:0] paddr;
    logic        fvalid;
    logic [63:0] faddr;
    logic [63:0] fdata;
    logic        fpf;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_req_scheduler_if #(.ADDR_W(64)) bus ();
  imem_req_scheduler_if #(.ADDR_W(64)) bus2 ();

  imem_req_scheduler #(.ADDR_W(64), .NUM_TAGS(15), .MAX_OUTSTANDING(MAXO), .PF_QDEPTH(DEPTH))
    dut (.clk(clk), .reset(reset), .bus(bus));
  imem_req_scheduler #(.ADDR_W(64), .NUM_TAGS(15), .MAX_OUTSTANDING(2), .PF_QDEPTH(DEPTH))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;
  out_t obs, exp_o;

  logic [63:0] m_q [$];
  logic [63:0] m_addr [int];
  bit          m_dem [int];

  function automatic in_t mk(bit mv, logic [63:0] ma, bit pv, logic [63:0] pa, bit fl, bit av,
                             int rs, int tg, logic [63:0] d);
    in_t r;
    r.miss_valid = mv; r.miss_addr = ma; r.pf_valid = pv; r.pf_addr = pa;
    r.flush = fl; r.avail = av; r.resp = 4'(rs); r.tag = 4'(tg); r.data = d;
    return r;
  endfunction

  function automatic int tbl_find(logic [63:0] a);
    foreach (m_addr[t]) if (m_addr[t] == a) return t;
    return 0;
  endfunction

  function automatic bit in_q(logic [63:0] a);
    foreach (m_q[i]) if (m_q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs for this cycle, then the state after the coming clock edge.
  function automatic void model(input in_t s);
    int hit, ft;
    bit can, head_hit, idem, ipf, acc, pop, dup, full;
    logic [63:0] iaddr;
    hit      = s.miss_valid ? tbl_find(s.miss_addr) : 0;
    can      = s.avail && (m_addr.num() < MAXO);
    head_hit = (m_q.size() > 0) && (tbl_find(m_q[0]) != 0);
    idem     = can && s.miss_valid && hit == 0;
    ipf      = can && !idem && m_q.size() > 0 && !head_hit;
    iaddr    = idem ? s.miss_addr : (ipf ? m_q[0] : 64'h0);
    acc      = (idem || ipf) && s.resp != 0;
    ft       = int'(s.tag);
    exp_o       = '0;
    exp_o.done  = (hit != 0) || (idem && acc);
    exp_o.stall = (m_q.size() == DEPTH);
    exp_o.cmd   = (idem || ipf) ? 2'd1 : 2'd0;
    exp_o.paddr = iaddr;
    if (ft != 0 && m_addr.exists(ft)) begin
      exp_o.fvalid = 1'b1;
      exp_o.faddr  = m_addr[ft];
      exp_o.fdata  = s.data;
      exp_o.fpf    = !m_dem[ft] && (hit != ft);
    end
    pop  = (can && head_hit) || (ipf && acc);
    dup  = in_q(s.pf_addr) || (tbl_find(s.pf_addr) != 0);
    full = (m_q.size() == DEPTH);
    if (hit != 0) m_dem[hit] = 1'b1;
    if (exp_o.fvalid) begin
      m_addr.delete(ft);
      m_dem.delete(ft);
    end
    if (acc) begin
      m_addr[int'(s.resp)] = iaddr;
      m_dem[int'(s.resp)]  = idem;
    end
    if (s.flush) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (s.pf_valid && !dup && (!full || pop)) m_q.push_back(s.pf_addr);
    end
  endfunction

  task automatic drive(input in_t s);
    bus.ic_miss_valid     = s.miss_valid;
    bus.ic_miss_addr      = s.miss_addr;
    bus.pf_request_valid  = s.pf_valid;
    bus.pf_requested_addr = s.pf_addr;
    bus.pf_flush          = s.flush;
    bus.mem_port_avail    = s.avail;
    bus.mem2proc_response = s.resp;
    bus.mem2proc_tag      = s.tag;
    bus.mem2proc_data     = s.data;
  endtask

  task automatic drive2(input bit mv, input logic [63:0] ma, input bit av, input int rs, input int tg);
    @(negedge clk);
    bus2.ic_miss_valid     = mv;
    bus2.ic_miss_addr      = ma;
    bus2.pf_request_valid  = 1'b0;
    bus2.pf_requested_addr = '0;
    bus2.pf_flush          = 1'b0;
    bus2.mem_port_avail    = av;
    bus2.mem2proc_response = 4'(rs);
    bus2.mem2proc_tag      = 4'(tg);
    bus2.mem2proc_data     = 64'h55;
    #1;
  endtask

  task automatic apply(input in_t s);
    @(negedge clk);
    drive(s);
    #1;
    obs = {bus.ic_miss_done, bus.pf_stall, bus.proc2mem_command, bus.proc2mem_addr,
           bus.fill_valid, bus.fill_addr, bus.fill_data, bus.fill_is_prefetch};
    model(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive('0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_q.delete();
    m_addr.delete();
    m_dem.delete();
  endtask

  task automatic test_reset();
    do_reset();
    apply('0);
    n_tests++;
    if (obs !== '0 || exp_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, out_t'('0));
    end
  endtask

  task automatic test_demand_issue();
    do_reset();
    apply(mk(1, 64'h100, 0, 0, 0, 1, 3, 0, 0));
    n_tests++;
    if (obs !== exp_o) begin n_fail++; $display("FAIL demand_issue_model: got %h expected %h", obs, exp_o); end
    n_tests++;
    if (obs.cmd !== 2'd1 || obs.paddr !== 64'h100 || obs.done !== 1'b1) begin
      n_fail++; $display("FAIL demand_issue: cmd %0d addr %h done %b, expected 1 100 1", obs.cmd, obs.paddr, obs.done);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 3, 64'hDEAD));
    n_tests++;
    if (obs.fvalid !== 1'b1 || obs.faddr !== 64'h100 || obs.fdata !== 64'hDEAD || obs.fpf !== 1'b0) begin
      n_fail++; $display("FAIL demand_fill: got %h", obs);
    end
  endtask

  task automatic test_priority_dedup();
    in_t seq [6];
    logic [63:0] ca [6];
    seq[0] = mk(0, 0,       1, 64'h200, 0, 0, 0, 0, 0);
    seq[1] = mk(0, 0,       1, 64'h208, 0, 0, 0, 0, 0);
    seq[2] = mk(1, 64'h300, 0, 0,       0, 1, 1, 0, 0);
    seq[3] = mk(0, 0,       0, 0,       0, 1, 2, 0, 0);
    seq[4] = mk(0, 0,       1, 64'h200, 0, 1, 4, 0, 0);
    seq[5] = mk(0, 0,       0, 0,       0, 1, 6, 0, 0);
    ca = '{64'h0, 64'h0, 64'h300, 64'h200, 64'h208, 64'h0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(seq[i]);
      n_tests++;
      if (obs !== exp_o || obs.paddr !== ca[i]) begin
        n_fail++; $display("FAIL priority_step%0d: got %h expected %h", i, obs, exp_o);
      end
    end
  endtask

  task automatic test_merge();
    do_reset();
    apply(mk(0, 0, 1, 64'h400, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, 5, 0, 0));
    n_tests++;
    if (obs !== exp_o || obs.paddr !== 64'h400) begin n_fail++; $display("FAIL merge_pf_issue: got %h", obs); end
    apply(mk(1, 64'h400, 0, 0, 0, 1, 7, 0, 0));
    n_tests++;
    if (obs !== exp_o || obs.done !== 1'b1 || obs.cmd !== 2'd0) begin
      n_fail++; $display("FAIL merge_done: done %b cmd %0d, expected 1 0", obs.done, obs.cmd);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 5, 64'h77));
    n_tests++;
    if (obs !== exp_o || obs.fvalid !== 1'b1 || obs.fpf !== 1'b0) begin
      n_fail++; $display("FAIL merge_fill: fvalid %b fpf %b, expected 1 0", obs.fvalid, obs.fpf);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    apply(mk(0, 0, 1, 64'h500, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      n_tests++;
      if (obs !== exp_o || obs.cmd !== 2'd1 || obs.paddr !== 64'h500) begin
        n_fail++; $display("FAIL retry%0d: cmd %0d addr %h, expected 1 500", i, obs.cmd, obs.paddr);
      end
    end
    apply(mk(0, 0, 0, 0, 0, 1, 9, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, 10, 0, 0));
    n_tests++;
    if (obs !== exp_o || obs.cmd !== 2'd0) begin n_fail++; $display("FAIL retry_drained: cmd %0d, expected 0", obs.cmd); end
  endtask

  task automatic test_cap();
    logic [63:0] ma [7];
    bit          mv [7];
    int          rs [7], tg [7];
    logic [1:0]  ecmd [7];
    logic        edone [7], efv [7];
    ma = '{64'h700, 64'h708, 64'h710, 64'h710, 64'h710, 64'h710, 64'h0};
    mv = '{1, 1, 1, 1, 1, 1, 0};
    rs = '{1, 2, 3, 3, 3, 3, 0};
    tg = '{0, 0, 0, 0, 1, 0, 0};
    ecmd  = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    edone = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    efv   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive2(mv[i], ma[i], 1'b1, rs[i], tg[i]);
      n_tests++;
      if (bus2.proc2mem_command !== ecmd[i] || bus2.ic_miss_done !== edone[i] || bus2.fill_valid !== efv[i]) begin
        n_fail++;
        $display("FAIL cap_step%0d: cmd %0d done %b fill %b, expected %0d %b %b", i,
                 bus2.proc2mem_command, bus2.ic_miss_done, bus2.fill_valid, ecmd[i], edone[i], efv[i]);
      end
    end
  endtask

  task automatic test_fifo_bounds();
    in_t seq [19];
    logic [0:18] cst;
    cst = 19'b0000111000000001000;
    seq[0]  = mk(0, 0, 1, 64'h800, 0, 0, 0, 0, 0);
    seq[1]  = mk(0, 0, 1, 64'h808, 0, 0, 0, 0, 0);
    seq[2]  = mk(0, 0, 1, 64'h810, 0, 0, 0, 0, 0);
    seq[3]  = mk(0, 0, 1, 64'h818, 0, 0, 0, 0, 0);
    seq[4]  = mk(0, 0, 1, 64'h820, 0, 0, 0, 0, 0);
    seq[5]  = mk(0, 0, 1, 64'h828, 0, 1, 1, 0, 0);
    for (int i = 6; i <= 10; i++) seq[i] = mk(0, 0, 0, 0, 0, 1, i - 4, 0, 0);
    for (int i = 11; i <= 14; i++) seq[i] = mk(0, 0, 1, 64'h840 + 64'((i - 11) * 8), 0, 0, 0, 0, 0);
    seq[15] = mk(0, 0, 0, 0,       1, 0, 0, 0, 0);
    seq[16] = mk(0, 0, 0, 0,       0, 0, 0, 0, 0);
    seq[17] = mk(0, 0, 1, 64'h860, 1, 0, 0, 0, 0);
    seq[18] = mk(0, 0, 0, 0,       0, 1, 7, 0, 0);
    do_reset();
    for (int i = 0; i < 19; i++) begin
      apply(seq[i]);
      n_tests++;
      if (obs !== exp_o || obs.stall !== cst[i]) begin
        n_fail++; $display("FAIL fifo_step%0d: got %h expected %h", i, obs, exp_o);
      end
    end
    n_tests++;
    if (obs.cmd !== 2'd0) begin n_fail++; $display("FAIL flush_push: cmd %0d, expected 0", obs.cmd); end
  endtask

  task automatic test_tag_reuse();
    do_reset();
    apply(mk(1, 64'h600, 0, 0, 0, 1, 2, 0, 0));
    apply(mk(1, 64'h608, 0, 0, 0, 1, 2, 2, 64'hBEEF));
    n_tests++;
    if (obs !== exp_o || obs.faddr !== 64'h600 || obs.paddr !== 64'h608 || obs.done !== 1'b1) begin
      n_fail++; $display("FAIL reuse_same_cycle: got %h expected %h", obs, exp_o);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 2, 64'h1));
    n_tests++;
    if (obs !== exp_o || obs.fvalid !== 1'b1 || obs.faddr !== 64'h608) begin
      n_fail++; $display("FAIL reuse_new_entry: fvalid %b addr %h, expected 1 608", obs.fvalid, obs.faddr);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 2, 64'h1));
    n_tests++;
    if (obs !== exp_o || obs.fvalid !== 1'b0) begin n_fail++; $display("FAIL reuse_freed: fvalid %b, expected 0", obs.fvalid); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int i = 1; i <= 3; i++) apply(mk(1, 64'h900 + 64'(i * 8), 0, 0, 0, 1, i, 0, 0));
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h9));
    n_tests++;
    if (obs !== exp_o || obs.fvalid !== 1'b0) begin n_fail++; $display("FAIL reset_inflight: fvalid %b, expected 0", obs.fvalid); end
  endtask

  task automatic test_random();
    bit          mpend = 1'b0;
    logic [63:0] maddr = '0;
    in_t         s;
    int          keys [$], cand [$];
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!mpend && $urandom_range(0, 2) == 0) begin
        mpend = 1'b1;
        maddr = 64'h1000 + 64'($urandom_range(0, 11) * 8);
      end
      s = '0;
      s.miss_valid = mpend;
      s.miss_addr  = maddr;
      s.pf_valid   = $urandom_range(0, 1) == 1;
      s.pf_addr    = 64'h1000 + 64'($urandom_range(0, 11) * 8);
      s.flush      = $urandom_range(0, 19) == 0;
      s.avail      = $urandom_range(0, 3) != 0;
      s.data       = {$urandom, $urandom};
      keys.delete();
      foreach (m_addr[t]) keys.push_back(t);
      if (keys.size() > 0 && $urandom_range(0, 2) == 0) s.tag = 4'(keys[$urandom_range(0, keys.size() - 1)]);
      else if ($urandom_range(0, 4) == 0) s.tag = 4'($urandom_range(1, 15));
      cand.delete();
      for (int t = 1; t <= 15; t++) if (!m_addr.exists(t) || (t == int'(s.tag))) cand.push_back(t);
      if ($urandom_range(0, 3) != 0 && cand.size() > 0) s.resp = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      apply(s);
      n_tests++;
      if (obs !== exp_o) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", cyc, obs, exp_o);
      end
      if (exp_o.done) mpend = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive('0);
    drive2(0, 0, 0, 0, 0);
    test_reset();
    test_demand_issue();
    test_priority_dedup();
    test_merge();
    test_backpressure();
    test_cap();
    test_fifo_bounds();
    test_tag_reuse();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_req_scheduler.md
Name: imem_req_scheduler

Overview:
Schedules the instruction-side memory port between I-cache demand misses and prefetcher requests. Prefetch requests pass through a small FIFO and are deduplicated against requests already in flight. Each issued request's memory tag is tracked, and returning data is routed back to the I-cache as a tagged fill. The block sits between the I-cache/prefetcher and the memory-bus arbiter, which grants the port when the D-side is idle.

Parameters:
ADDR_W, 64, byte address width; block-aligned addresses, low 3 bits always 0
NUM_TAGS, 15, memory tags 1..NUM_TAGS; tag 0 means "no response"
MAX_OUTSTANDING, 8, cap on in-flight requests, 1..NUM_TAGS
PF_QDEPTH, 4, prefetch FIFO depth, power of 2, at least 2

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
ic_miss_valid  in  1  I-cache demand miss pending (held until ic_miss_done)
ic_miss_addr  in  ADDR_W  demand block address
ic_miss_done  out  1  demand issued, or merged with an in-flight request, this cycle
pf_request_valid  in  1  prefetcher request
pf_requested_addr  in  ADDR_W  prefetch block address
pf_stall  out  1  prefetch FIFO full; a push while high is dropped
pf_flush  in  1  branch mispredict; clears the prefetch FIFO
mem_port_avail  in  1  bus arbiter grants the I-side this cycle
proc2mem_command  out  2  0=BUS_NONE, 1=BUS_LOAD
proc2mem_addr  out  ADDR_W  issue address
mem2proc_response  in  4  tag accepted this cycle; 0 = rejected
mem2proc_tag  in  4  tag of returning data; 0 = none
mem2proc_data  in  64  returning block data
fill_valid  out  1  fill delivered this cycle
fill_addr  out  ADDR_W  address of the fill
fill_data  out  64  fill data
fill_is_prefetch  out  1  no demand was ever attached to this fill

Behaviour:
- Reset: FIFO empty, all table entries invalid, outstanding count 0. All outputs 0 (proc2mem_command=BUS_NONE).
- Table: one entry per tag, holding {valid, addr, demand}. The outstanding count equals the number of valid entries.
- Hit check: an address "hits" if it matches a valid entry's addr. It is checked combinationally against the table state at the start of the cycle.
- Issue is considered only when mem_port_avail=1 and outstanding < MAX_OUTSTANDING. Priority order:
  1. Demand: ic_miss_valid=1 and the address misses the table.
  2. FIFO head: head misses the table.
- A FIFO head that hits the table is popped without issue; this does not consume the port, so a demand can still issue that cycle.
- A demand that hits the table: the entry's demand bit is set, ic_miss_done=1, no issue. This is independent of mem_port_avail.
- Issue occurs in the same cycle: proc2mem_command=BUS_LOAD, proc2mem_addr=chosen address.
  - mem2proc_response≠0: allocate the table entry at that tag at the clock edge (valid=1, demand=1 for a demand issue), then pop the FIFO or assert ic_miss_done.
  - mem2proc_response=0: nothing is consumed; the same choice is retried next cycle.
- Fill: mem2proc_tag≠0 with a valid entry gives, combinationally in the same cycle, fill_valid=1, fill_addr=entry addr, fill_data=mem2proc_data, fill_is_prefetch=!demand. The entry is freed at the clock edge. A tag with no valid entry is ignored (fill_valid=0).
- Fill-cycle hit check: a demand that hits an entry being filled this cycle counts as a hit. ic_miss_done=1, and fill_is_prefetch is forced to 0.
- Same tag freed and allocated in one cycle: allocation wins and the entry stays valid with the new contents. The outstanding count nets ±0.
- FIFO push: pf_request_valid=1 and not full.
  - Push while full: dropped.
  - Push and pop together while full: the pop frees a slot and the push succeeds.
  - A push whose address equals any FIFO entry or table entry: dropped.
  - pf_stall = full, registered state.
- pf_flush: at the clock edge the FIFO is empty and any same-cycle push or pop is discarded. In-flight table entries are unaffected; their fills still arrive with fill_is_prefetch=1.
- Pointer wrap: read/write pointers wrap modulo PF_QDEPTH. A count register of $clog2(PF_QDEPTH)+1 bits distinguishes full from empty.
- Reset mid-operation: all state is cleared. A later mem2proc_tag for a pre-reset request has no valid entry and is ignored.

Test Plan:
- Demand issue: ic_miss_valid=1, addr=0x100, mem_port_avail=1, response=3 → BUS_LOAD 0x100, ic_miss_done=1. Later tag=3, data=0xDEAD → fill_valid=1, fill_addr=0x100, fill_is_prefetch=0.
- Priority and dedup: FIFO holds 0x200 and 0x208; demand 0x300 arrives in the same cycle → 0x300 issues first, then 0x200, then 0x208. Pushing 0x200 again while it is in flight is dropped and no second issue occurs.
- Merge: prefetch 0x400 in flight on tag 5; demand 0x400 arrives → ic_miss_done=1 with no BUS_LOAD. The fill on tag 5 has fill_is_prefetch=0.
- Backpressure: response=0 for 3 cycles → proc2mem_addr held constant and the FIFO is not popped. With MAX_OUTSTANDING=2 and two requests in flight → BUS_NONE until a fill frees an entry.
- FIFO boundaries: push 4 distinct addresses with mem_port_avail=0 → pf_stall=1 and a 5th push is dropped. pf_flush while full → empty and pf_stall=0 next cycle. Flush concurrent with a push → FIFO still empty.
- Corner cases:
  - Fill on tag 2 while a new request gets response=2 in the same cycle → entry holds the new address and outstanding is unchanged.
  - Reset with 3 requests in flight → a subsequent tag=1 return gives fill_valid=0.
